// File: rtl/byte_unstrip_pkg.sv
// ---------------------------------------------------------------------------
// byte_unstrip_pkg
// Shared definitions for the lane striping pair (byte_strip / byte_unstrip):
//   - 8b/10b K-symbol code points used on the lanes
//   - the packed lane-group entry stored in the group FIFO
//   - serializer state encoding
//   - is_k_code(): membership test for the recognised K set
// ---------------------------------------------------------------------------
package byte_unstrip_pkg;

   localparam int DATA_W  = 8;               // one lane byte
   localparam int LANES   = 4;               // lanes per group
   localparam int GRP_W   = LANES * DATA_W + LANES;

   localparam logic [DATA_W-1:0] K_STP = 8'hFB;
   localparam logic [DATA_W-1:0] K_SDP = 8'h5C;
   localparam logic [DATA_W-1:0] K_END = 8'hFD;
   localparam logic [DATA_W-1:0] K_EDB = 8'hFE;
   localparam logic [DATA_W-1:0] K_COM = 8'hBC;
   localparam logic [DATA_W-1:0] K_SKP = 8'h1C;
   localparam logic [DATA_W-1:0] K_IDL = 8'h7C;

   // LANE0 occupies data[7:0] and dk[0]; lane k sits at data[8k +: 8].
   typedef struct packed {
      logic [LANES-1:0]        dk;
      logic [LANES*DATA_W-1:0] data;
   } lane_group_t;

   typedef enum logic [0:0] {
      SER_IDLE = 1'b0,
      SER_SEND = 1'b1
   } ser_state_t;

   function automatic logic is_k_code(input logic [DATA_W-1:0] b);
      logic hit;
      hit = 1'b0;
      case (b)
         K_STP, K_SDP, K_END, K_EDB, K_COM, K_SKP, K_IDL: hit = 1'b1;
         default:                                          hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/byte_unstrip_fifo.sv
// ---------------------------------------------------------------------------
// lane_group_fifo
// Two-entry FIFO holding whole lane groups (32 data bits + 4 K flags).
// Ports:
//   CLK      clock, rising edge
//   RESET_L  synchronous active-low reset; empties the FIFO
//   push     write wdata (ignored when full)
//   wdata    lane group to store
//   pop      drop the head entry (ignored when empty)
//   rdata    head entry, valid whenever empty=0
//   full     both entries occupied
//   empty    no entry occupied
//   level    occupancy 0..2
// ---------------------------------------------------------------------------
module lane_group_fifo
   import byte_unstrip_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET_L,
   input  logic        push,
   input  lane_group_t wdata,
   input  logic        pop,
   output lane_group_t rdata,
   output logic        full,
   output logic        empty,
   output logic [1:0]  level
);

   lane_group_t mem [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic        push_ok;
   logic        pop_ok;

   assign full    = (level == 2'd2);
   assign empty   = (level == 2'd0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Control: pointers and occupancy
   always_ff @(posedge CLK) begin
      if (!RESET_L) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         level  <= 2'd0;
      end else begin
         if (push_ok) wr_ptr <= ~wr_ptr;
         if (pop_ok)  rd_ptr <= ~rd_ptr;
         level <= level + 2'(push_ok) - 2'(pop_ok);
      end
   end

   // Storage: contents are don't-care until written, so no reset
   always_ff @(posedge CLK) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/byte_unstrip.sv
// ---------------------------------------------------------------------------
// byte_unstrip
// Collects 4-lane byte groups into a 2-deep FIFO and serializes them onto a
// single byte stream, LANE0 first. Flags unknown K codes and can optionally
// suppress SKP ordered-set symbols.
// Parameters:
//   DROP_SKP   1 = slots carrying K-SKP (1C) produce no valid output
// Ports:
//   CLK, RESET_L          clock, synchronous active-low reset
//   LANE0..LANE3, DK_0..3 lane bytes and K flags of one group
//   IN_VALID / IN_READY   group handshake; IN_READY is registered
//   D, DK                 serial byte and its K flag (registered)
//   VALID_OUT             D/DK carry a byte this cycle
//   ERR                   K flag set on a byte outside the K set
// ---------------------------------------------------------------------------
module byte_unstrip
   import byte_unstrip_pkg::*;
#(
   parameter bit DROP_SKP = 1'b0
)(
   input  logic              CLK,
   input  logic              RESET_L,
   input  logic [DATA_W-1:0] LANE0,
   input  logic [DATA_W-1:0] LANE1,
   input  logic [DATA_W-1:0] LANE2,
   input  logic [DATA_W-1:0] LANE3,
   input  logic              DK_0,
   input  logic              DK_1,
   input  logic              DK_2,
   input  logic              DK_3,
   input  logic              IN_VALID,
   output logic              IN_READY,
   output logic [DATA_W-1:0] D,
   output logic              DK,
   output logic              VALID_OUT,
   output logic              ERR
);

   lane_group_t       fifo_wdata;
   lane_group_t       head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [1:0]        fifo_level;
   logic [1:0]        level_next;
   logic              push;
   logic              pop;
   logic              emit;
   logic              skp_drop;

   ser_state_t        state;
   logic [1:0]        slot;
   logic [DATA_W-1:0] slot_byte;
   logic              slot_dk;

   logic [DATA_W-1:0] d_p1;
   logic              dk_p1;
   logic              vld_p1;
   logic              err_p1;
   logic              rdy_p1;

   assign fifo_wdata = '{dk:   {DK_3, DK_2, DK_1, DK_0},
                         data: {LANE3, LANE2, LANE1, LANE0}};

   // IN_READY already guarantees space; !fifo_full only keeps the handshake
   // and the FIFO in exact agreement.
   assign push = IN_VALID && rdy_p1 && !fifo_full;

   // A slot is emitted every cycle the head entry exists. In SEND the FIFO is
   // never empty, so the state term only documents the intent.
   assign emit = (state == SER_SEND) || !fifo_empty;
   assign pop  = emit && (slot == 2'd3);

   // Occupancy as it will be after this edge; IN_READY is derived from it so
   // that no path exists from IN_VALID to IN_READY within a cycle.
   assign level_next = fifo_level + 2'(push) - 2'(pop);

   lane_group_fifo u_fifo (
      .CLK     (CLK),
      .RESET_L (RESET_L),
      .push    (push),
      .wdata   (fifo_wdata),
      .pop     (pop),
      .rdata   (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   always_comb begin
      slot_byte = head.data[{slot, 3'b000} +: DATA_W];
      slot_dk   = head.dk[slot];
      skp_drop  = DROP_SKP && slot_dk && (slot_byte == K_SKP);
   end

   // Stage p1: serializer state, lane counter and registered outputs
   always_ff @(posedge CLK) begin
      if (!RESET_L) begin
         state  <= SER_IDLE;
         slot   <= 2'd0;
         rdy_p1 <= 1'b0;
         d_p1   <= '0;
         dk_p1  <= 1'b0;
         vld_p1 <= 1'b0;
         err_p1 <= 1'b0;
      end else begin
         rdy_p1 <= (level_next < 2'd2);
         vld_p1 <= 1'b0;
         err_p1 <= 1'b0;
         if (emit) begin
            slot <= slot + 2'd1;
            // Stay in SEND across a group boundary when another group is
            // (or is just being) queued, giving back-to-back output.
            if ((slot == 2'd3) && (level_next == 2'd0))
               state <= SER_IDLE;
            else
               state <= SER_SEND;
            // A dropped SKP still consumes its slot; D/DK keep their value.
            if (!skp_drop) begin
               d_p1   <= slot_byte;
               dk_p1  <= slot_dk;
               vld_p1 <= 1'b1;
               err_p1 <= slot_dk && !is_k_code(slot_byte);
            end
         end else begin
            state <= SER_IDLE;
         end
      end
   end

   assign IN_READY  = rdy_p1;
   assign D         = d_p1;
   assign DK        = dk_p1;
   assign VALID_OUT = vld_p1;
   assign ERR       = err_p1;

endmodule

// File: tb/tb_byte_unstrip.sv
module tb_byte_unstrip;

   logic       CLK;
   logic       RESET_L;
   logic [7:0] lane [4];
   logic       dkv  [4];
   logic       IN_VALID;

   logic       rdy0, dk0, vld0, err0;
   logic [7:0] d0;
   logic       rdy1, dk1, vld1, err1;
   logic [7:0] d1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference streams: {ERR, DK, byte} expected in order, per instance
   logic [9:0] q0[$];
   logic [9:0] q1[$];

   logic last_acc;
   int   nvalid, first_v, last_v;
   logic saw_low;

   byte_unstrip #(.DROP_SKP(1'b0)) dut (
      .CLK(CLK), .RESET_L(RESET_L),
      .LANE0(lane[0]), .LANE1(lane[1]), .LANE2(lane[2]), .LANE3(lane[3]),
      .DK_0(dkv[0]), .DK_1(dkv[1]), .DK_2(dkv[2]), .DK_3(dkv[3]),
      .IN_VALID(IN_VALID), .IN_READY(rdy0),
      .D(d0), .DK(dk0), .VALID_OUT(vld0), .ERR(err0)
   );

   byte_unstrip #(.DROP_SKP(1'b1)) dut_drop (
      .CLK(CLK), .RESET_L(RESET_L),
      .LANE0(lane[0]), .LANE1(lane[1]), .LANE2(lane[2]), .LANE3(lane[3]),
      .DK_0(dkv[0]), .DK_1(dkv[1]), .DK_2(dkv[2]), .DK_3(dkv[3]),
      .IN_VALID(IN_VALID), .IN_READY(rdy1),
      .D(d1), .DK(dk1), .VALID_OUT(vld1), .ERR(err1)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic known_k(input logic [7:0] b);
      return b inside {8'hFB, 8'h5C, 8'hFD, 8'hFE, 8'hBC, 8'h1C, 8'h7C};
   endfunction

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expand an accepted group into the serial byte streams each instance owes.
   task automatic model_push();
      for (int k = 0; k < 4; k++) begin
         logic [9:0] e;
         e = {dkv[k] && !known_k(lane[k]), dkv[k], lane[k]};
         q0.push_back(e);
         if (!(dkv[k] && lane[k] == 8'h1C)) q1.push_back(e);
      end
   endtask

   task automatic score(input bit which, input logic v, input logic e,
                        input logic k, input logic [7:0] d);
      logic [9:0] x;
      int sz;
      sz = which ? q1.size() : q0.size();
      if (v) begin
         chk(which ? "drop_has_expected" : "nodrop_has_expected", 36'(sz != 0), 36'd1);
         if (sz != 0) begin
            x = which ? q1.pop_front() : q0.pop_front();
            chk(which ? "drop_stream" : "nodrop_stream", 36'({e, k, d}), 36'(x));
         end
      end else begin
         chk(which ? "drop_err_idle" : "nodrop_err_idle", 36'(e), 36'd0);
      end
   endtask

   task automatic tick();
      logic acc, rst_edge;
      acc      = IN_VALID && rdy0 && RESET_L;
      rst_edge = !RESET_L;
      @(posedge CLK);
      cyc++;
      if (rst_edge) begin
         q0.delete();
         q1.delete();
      end else if (acc) begin
         model_push();
      end
      last_acc = acc;
      #1;
      if (vld0) begin
         nvalid++;
         if (first_v < 0) first_v = cyc;
         last_v = cyc;
      end
      if (!rdy0) saw_low = 1'b1;
      score(1'b0, vld0, err0, dk0, d0);
      score(1'b1, vld1, err1, dk1, d1);
   endtask

   task automatic set_group(input logic [31:0] bytes, input logic [3:0] k);
      for (int i = 0; i < 4; i++) begin
         lane[i] = bytes[8*i +: 8];
         dkv[i]  = k[i];
      end
   endtask

   // Present the group on the lanes and hold IN_VALID until it is taken.
   task automatic push_group(input logic [31:0] bytes, input logic [3:0] k);
      set_group(bytes, k);
      IN_VALID = 1'b1;
      for (int t = 0; t < 40; t++) begin
         tick();
         if (last_acc) return;
      end
      chk("push_timeout", 36'd0, 36'd1);
   endtask

   task automatic drain();
      IN_VALID = 1'b0;
      for (int t = 0; t < 300 && (q0.size() != 0 || q1.size() != 0); t++) tick();
      chk("drain_nodrop_empty", 36'(q0.size()), 36'd0);
      chk("drain_drop_empty", 36'(q1.size()), 36'd0);
   endtask

   logic [7:0] kcodes [7];

   initial begin
      kcodes = '{8'hFB, 8'h5C, 8'hFD, 8'hFE, 8'hBC, 8'h1C, 8'h7C};
      RESET_L  = 1'b0;
      IN_VALID = 1'b0;
      set_group(32'h0, 4'h0);
      nvalid = 0; first_v = -1; last_v = -1; saw_low = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_D", 36'(d0), 36'd0);
      chk("rst_DK", 36'(dk0), 36'd0);
      chk("rst_VALID", 36'(vld0), 36'd0);
      chk("rst_ERR", 36'(err0), 36'd0);
      chk("rst_READY", 36'(rdy0), 36'd0);
      chk("rst_READY_drop", 36'(rdy1), 36'd0);
      RESET_L = 1'b1;
      tick();
      chk("ready_after_reset", 36'(rdy0), 36'd1);

      // Single group, exact latency
      push_group(32'h44332211, 4'b0000);
      IN_VALID = 1'b0;
      chk("single_not_yet", 36'(vld0), 36'd0);
      for (int k = 0; k < 4; k++) begin
         logic [31:0] g;
         g = 32'h44332211;
         tick();
         chk("single_valid", 36'(vld0), 36'd1);
         chk("single_byte", 36'(d0), 36'(g[8*k +: 8]));
      end
      tick();
      chk("single_done", 36'(vld0), 36'd0);

      // Three groups with IN_VALID held high: contiguous 12 bytes
      nvalid = 0; first_v = -1; last_v = -1; saw_low = 1'b0;
      push_group(32'hA3A2A1A0, 4'b0000);
      push_group(32'hB3B2B1B0, 4'b0000);
      push_group(32'hC3C2C1C0, 4'b0000);
      drain();
      chk("burst_count", 36'(nvalid), 36'd12);
      chk("burst_contig", 36'(last_v - first_v + 1), 36'd12);
      chk("burst_ready_dropped", 36'(saw_low), 36'd1);

      // SKP suppression: lanes BC,1C,FB,55 with K flags on lanes 0..2
      push_group(32'h55FB1CBC, 4'b0111);
      IN_VALID = 1'b0;
      tick();
      chk("skp_s0_vld", 36'(vld1), 36'd1);
      chk("skp_s0_d", 36'({dk1, d1}), 36'h1BC);
      tick();
      chk("skp_s1_vld_drop", 36'(vld1), 36'd0);
      chk("skp_s1_hold", 36'({dk1, d1}), 36'h1BC);
      chk("skp_s1_vld_nodrop", 36'({vld0, dk0, d0}), 36'h31C);
      tick();
      chk("skp_s2_d", 36'({vld1, dk1, d1}), 36'h3FB);
      tick();
      chk("skp_s3_d", 36'({vld1, dk1, d1}), 36'h255);
      drain();

      // Unknown K code on lane 2
      push_group(32'h03AA0201, 4'b0100);
      IN_VALID = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("kerr_flag", 36'(err0), 36'(k == 2));
      end
      drain();

      // Reset in the middle of a queued pair
      push_group(32'h13121110, 4'b0000);
      push_group(32'h23222120, 4'b0000);
      IN_VALID = 1'b0;
      tick();
      chk("midrst_slot1", 36'({vld0, d0}), 36'h111);
      RESET_L = 1'b0;
      tick();
      chk("midrst_outs", 36'({rdy0, vld0, err0, dk0, d0}), 36'd0);
      RESET_L = 1'b1;
      tick();
      chk("midrst_ready", 36'(rdy0), 36'd1);
      for (int t = 0; t < 5; t++) tick();
      push_group(32'h33323130, 4'b0000);
      drain();

      // Random stream with K symbols, bad K codes and input gaps
      for (int g = 0; g < 40; g++) begin
         logic [31:0] b;
         logic [3:0]  k;
         for (int i = 0; i < 4; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 3) begin
               b[8*i +: 8] = kcodes[$urandom_range(0, 6)];
               k[i] = 1'b1;
            end else begin
               b[8*i +: 8] = 8'($urandom);
               k[i] = (r == 3);
            end
         end
         if ($urandom_range(0, 3) == 0) begin
            IN_VALID = 1'b0;
            for (int t = 0; t < int'($urandom_range(1, 6)); t++) tick();
         end
         push_group(b, k);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/byte_unstrip.md
BYTE_UNSTRIP -- requirements
Module: byte_unstrip

Interface
REQ-001 Parameter: DROP_SKP, default 0; 1 = suppress SKP symbols from the output stream.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET_L  input  1  reset, synchronous, active-low.
REQ-004 LANE0..LANE3  input  8 each  lane bytes of one group; LANE0 is first in serial order.
REQ-005 DK_0..DK_3  input  1 each  control-symbol flag per lane (1 = K symbol).
REQ-006 IN_VALID  input  1  lane group on LANE*/DK_* is valid.
REQ-007 IN_READY  output  1  block accepts a group this cycle; registered.
REQ-008 D  output  8  serial byte out; registered.
REQ-009 DK  output  1  control flag of D; registered.
REQ-010 VALID_OUT  output  1  D/DK carry a valid byte this cycle; registered.
REQ-011 ERR  output  1  one-cycle pulse, aligned with D: DK=1 on an unknown K code.

Function
REQ-012 Group accepted at a rising edge where IN_VALID=1 and IN_READY=1; written into a 2-entry group FIFO (32 data bits + 4 DK bits per entry).
REQ-013 IN_READY = 1 when FIFO occupancy < 2 at the previous edge; no combinational path from IN_VALID.
REQ-014 IN_VALID while IN_READY=0: group ignored, no state change.
REQ-015 Serializer: 2-bit lane counter 0..3; slot k drives LANE k byte and DK of the head entry onto D/DK.
REQ-016 Serializer states: IDLE (FIFO empty, VALID_OUT=0) and SEND (counter advancing 1 per cycle).
REQ-017 IDLE->SEND when FIFO non-empty at an edge; slot 0 registered at the next edge.
REQ-018 Latency: group accepted at edge E into an empty FIFO with serializer idle -> lane k on D after edge E+1+k.
REQ-019 Counter wraps 3->0; head entry popped at the edge that registers slot 3.
REQ-020 If the FIFO is non-empty after the pop, the next group's slot 0 follows back-to-back with no bubble; otherwise SEND->IDLE.
REQ-021 Simultaneous push and pop at one edge: both take effect; occupancy is unchanged.
REQ-022 Push into an empty FIFO while the last slot of the previous group is emitted: the new group's slot 0 follows immediately.
REQ-023 Sustained throughput: 1 group per 4 cycles; a faster input is throttled only by IN_READY.
REQ-024 K codes: STP=FB, SDP=5C, END=FD, EDB=FE, COM=BC, SKP=1C, IDL=7C.
REQ-025 DROP_SKP=1 and slot has DK=1 with byte 1C: slot time is still consumed; VALID_OUT=0 for that slot; D/DK hold their previous value.
REQ-026 Slot with DK=1 and a byte not in the K set: byte output normally; ERR=1 for that cycle.
REQ-027 DK=0 bytes are never checked; any value passes.
REQ-028 VALID_OUT=0 implies ERR=0.

Reset
REQ-029 While RESET_L=0 at an edge: FIFO empty, counter=0, state IDLE, D=00, DK=0, VALID_OUT=0, ERR=0, IN_READY=0.
REQ-030 IN_READY=1 after the first edge with RESET_L=1.
REQ-031 Reset mid-group: the partial group and all queued groups are discarded; no further bytes of them appear.

Structure
REQ-032 The K-symbol constants (REQ-024) live in a shared package or include, also used by byte_strip.
REQ-033 The FIFO is the sub-module lane_group_fifo (depth 2, 36-bit entries, push/pop, full/empty, synchronous active-low reset).
REQ-034 The serializer, K check and SKP drop live in byte_unstrip.

Verification
REQ-035 Single group LANE0..3 = 11,22,33,44, DK=0000, accepted at edge E -> D = 11,22,33,44 after E+1..E+4 with VALID_OUT=1; VALID_OUT=0 after E+5.
REQ-036 IN_VALID held high with groups A, B, C -> 12 contiguous bytes with no bubble; IN_READY drops while 2 groups are queued; no group is lost or duplicated.
REQ-037 Group BC,1C,FB,55 with DK=1110 and DROP_SKP=1 -> valid outputs BC(DK=1), FB(DK=1), 55(DK=0); slot 1 has VALID_OUT=0; with DROP_SKP=0 all 4 bytes are valid.
REQ-038 Group with DK_2=1 and LANE2=AA -> ERR=1 only in the cycle D=AA; no ERR for the other slots.
REQ-039 RESET_L=0 for one cycle after slot 1 of a queued pair -> all outputs 0 next cycle; IN_READY=1 one cycle later; a new group serializes cleanly.
REQ-040 Loopback D/DK from byte_strip into byte_unstrip, random stream including K symbols -> output stream equals input stream, order preserved.
